buffer2axis: RTL
================

BUFFER2AXIS -- requirements
Module: buffer2axis

Interface
REQ-001 Parameter DWIDTH, default 32, pixel/color width in bits and the M_AXIS_TDATA width.
REQ-002 Parameter WIDTH, default 32, grid columns.
REQ-003 Parameter HEIGHT, default 32, grid rows; N = WIDTH*HEIGHT cells per frame.
REQ-004 Port clk  in  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 Port rst  in  1  reset; synchronous, active-high.
REQ-006 Port alive_color  in  DWIDTH  color emitted for a cell value of 1.
REQ-007 Port dead_color  in  DWIDTH  color emitted for a cell value of 0.
REQ-008 Port in_data  in  N  binary grid from the conware computation; bit i = cell i, row-major, bit 0 = top-left.
REQ-009 Port in_valid  in  1  in_data holds a complete frame.
REQ-010 Port in_ready  out  1  block can accept a frame.
REQ-011 Port M_AXIS_TDATA  out  DWIDTH  pixel color.
REQ-012 Port M_AXIS_TVALID  out  1  beat valid.
REQ-013 Port M_AXIS_TREADY  in  1  downstream accepts beat.
REQ-014 Port M_AXIS_TLAST  out  1  last beat of frame (cell N-1).
REQ-015 Port M_AXIS_TUSER  out  1  start of frame (cell 0).
REQ-016 Port frame_done  out  1  one-cycle pulse when the last beat is accepted.

Function
REQ-017 Two-state FSM SHALL be implemented: IDLE, SEND.
REQ-018 IDLE: in_ready=1, M_AXIS_TVALID=0; SEND: in_ready=0, M_AXIS_TVALID=1.
REQ-019 Frame accept: in IDLE with in_valid=1, in_data, alive_color and dead_color SHALL be captured into internal registers, cell counter cleared to 0, FSM -> SEND on the next edge.
REQ-020 Latency: first beat SHALL be valid the cycle after the in_valid&&in_ready edge.
REQ-021 In SEND, M_AXIS_TDATA SHALL equal captured alive_color if captured bit[counter]=1, else captured dead_color.
REQ-022 Color or in_data changes after capture SHALL NOT affect the frame in flight.
REQ-023 M_AXIS_TUSER = 1 iff SEND and counter=0; M_AXIS_TLAST = 1 iff SEND and counter=N-1.
REQ-024 Beat transfer = M_AXIS_TVALID && M_AXIS_TREADY; counter SHALL increment by 1 per transfer and hold otherwise.
REQ-025 While stalled (TREADY=0), TDATA/TUSER/TLAST/TVALID SHALL remain stable; no combinational path from M_AXIS_TREADY to any output.
REQ-026 Transfer at counter=N-1: counter -> 0, FSM -> IDLE, frame_done=1 the following cycle for exactly one cycle.
REQ-027 Counter width SHALL be clog2(N) bits minimum; counter SHALL never exceed N-1.
REQ-028 Back-to-back frames: minimum one IDLE cycle between frames; frame rate ceiling N+1 cycles/frame.
REQ-029 in_valid asserted during SEND SHALL be ignored (not captured) until return to IDLE.
REQ-030 Exactly N beats per frame; no beats dropped or duplicated under any TREADY pattern.

Reset
REQ-031 rst=1 at a clock edge SHALL force: FSM=IDLE, counter=0, in_ready=1 the next cycle, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0, frame_done=0.
REQ-032 rst mid-frame SHALL abort the frame; no further beats of it; next frame starts at cell 0 with TUSER=1.
REQ-033 Captured grid/color registers need no reset value; TDATA is don't-care while TVALID=0.

Verification (WIDTH=HEIGHT=4, N=16, DWIDTH=32, alive=0x00FFFFFF, dead=0x00000000)
REQ-034 in_data=16'h8001, TREADY=1 -> 16 beats on consecutive cycles starting 1 cycle after accept; beats 0 and 15 = 0x00FFFFFF, others 0; TUSER on beat 0, TLAST on beat 15, frame_done 1 cycle after beat 15.
REQ-035 in_data=16'hA5A5, TREADY toggling 1/0 each cycle -> 16 beats in 31 cycles, pattern matches bits, outputs stable across stalls.
REQ-036 alive_color changed to 0x12345678 at cycle 3 of SEND -> all beats of current frame still 0x00FFFFFF; next frame uses 0x12345678.
REQ-037 in_valid held high continuously, TREADY=1 -> frames every 17 cycles, in_ready low during each SEND.
REQ-038 rst pulsed after beat 7 accepted -> TVALID=0 next cycle, in_ready=1; next frame starts at beat 0 with TUSER=1.
REQ-039 TREADY=0 for 50 cycles at beat 15 -> TLAST, TVALID, TDATA held 50 cycles; frame_done only after the accepting edge.

Source files
------------

// File: rtl/buffer2axis.sv
// Streams a captured binary grid out over AXI4-Stream, one color per cell in row-major order.
// A frame is captured whole in IDLE and replayed from private copies, so inputs may change freely while it is sent.
module buffer2axis #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH-1:0]        alive_color,
  input  logic [DWIDTH-1:0]        dead_color,
  input  logic [WIDTH*HEIGHT-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DWIDTH-1:0]        M_AXIS_TDATA,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic                     M_AXIS_TLAST,
  output logic                     M_AXIS_TUSER,
  output logic                     frame_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              last_beat;
  logic              accept;
  logic              advance;
  logic [N-1:0]      grid_q;
  logic [DWIDTH-1:0] alive_q;
  logic [DWIDTH-1:0] dead_q;

  assign cnt_next  = cnt + CW'(1);
  assign last_beat = (cnt == LAST);
  assign accept    = (state == IDLE) && in_valid;
  // Only the registered TVALID qualifies a transfer, so TREADY never reaches an output combinationally.
  assign advance   = (state == SEND) && M_AXIS_TREADY;

  // Control path: state, cell counter and every handshake/sideband output are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      in_ready      <= 1'b1;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state         <= SEND;
            cnt           <= '0;
            in_ready      <= 1'b0;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TUSER  <= 1'b1;
            M_AXIS_TLAST  <= (N == 1);
          end
        end
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (last_beat) begin
              state         <= IDLE;
              cnt           <= '0;
              in_ready      <= 1'b1;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TUSER  <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              frame_done    <= 1'b1;
            end else begin
              cnt          <= cnt_next;
              M_AXIS_TUSER <= 1'b0;
              M_AXIS_TLAST <= (cnt_next == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the grid, color copies and TDATA carry no reset: their contents are only
  // observed while TVALID is high, and a reset-free data path stays a plain enable flop.
  always_ff @(posedge clk) begin
    if (accept) begin
      grid_q       <= in_data;
      alive_q      <= alive_color;
      dead_q       <= dead_color;
      M_AXIS_TDATA <= in_data[0] ? alive_color : dead_color;
    end else if (advance && !last_beat) begin
      M_AXIS_TDATA <= grid_q[cnt_next] ? alive_q : dead_q;
    end
  end

endmodule
